// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: accepts one full-line read or write from the cache arbiter
// and turns it into a BEATS-long burst on the memory port (beat 0 = lowest bits).
// Optional build macro CACHELINE_ADAPTOR_EARLY_RESP_EN: drops the DONE cycle and
// raises line_resp combinationally in the final-beat cycle.
`timescale 1ns/1ps
module cacheline_adaptor #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read,
  input  logic                  line_write,
  input  logic [31:0]           line_address,
  input  logic [LINE_WIDTH-1:0] line_wdata,
  output logic [LINE_WIDTH-1:0] line_rdata,
  output logic                  line_resp,
  output logic [31:0]           burst_address,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_resp
);
  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [LINE_WIDTH-1:0] line_buf;
  logic                  last_beat;
  logic [4:0]            addr_unused;

  // Line offset bits never reach the memory port.
  assign addr_unused = line_address[4:0];

  // Acknowledge of the final beat of the current burst.
  assign last_beat = ((state == READ) || (state == WRITE)) && burst_resp && (cnt == LAST);

  // Write beat is a pure mux off the buffer; zero whenever no write burst is active.
  assign burst_wdata = burst_write ? line_buf[cnt*BEAT_WIDTH +: BEAT_WIDTH] : '0;

`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
  assign line_resp  = last_beat;
  // Final read beat is forwarded straight through so the line is complete this cycle.
  assign line_rdata = (last_beat && (state == READ))
                    ? {burst_rdata, line_buf[LINE_WIDTH-BEAT_WIDTH-1:0]} : line_buf;
`else
  logic resp_q;
  assign line_resp  = resp_q;
  assign line_rdata = line_buf;
`endif

  // Request acceptance, beat counting and burst command flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      line_buf      <= '0;
      burst_address <= '0;
      burst_read    <= 1'b0;
      burst_write   <= 1'b0;
`ifndef CACHELINE_ADAPTOR_EARLY_RESP_EN
      resp_q        <= 1'b0;
`endif
    end else begin
`ifndef CACHELINE_ADAPTOR_EARLY_RESP_EN
      resp_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Read wins a tie; a still-held write is picked up on a later IDLE.
          if (line_read) begin
            burst_address <= {line_address[31:5], 5'b0};
            cnt           <= '0;
            burst_read    <= 1'b1;
            state         <= READ;
          end else if (line_write) begin
            burst_address <= {line_address[31:5], 5'b0};
            line_buf      <= line_wdata;
            cnt           <= '0;
            burst_write   <= 1'b1;
            state         <= WRITE;
          end
        end
        READ: begin
          if (burst_resp) begin
            line_buf[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= burst_rdata;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              burst_read <= 1'b0;
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
              state      <= IDLE;
`else
              state      <= DONE;
              resp_q     <= 1'b1;
`endif
            end
          end
        end
        WRITE: begin
          if (burst_resp) begin
            cnt <= cnt + CW'(1);
            if (cnt == LAST) begin
              burst_write <= 1'b0;
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
              state       <= IDLE;
`else
              state       <= DONE;
              resp_q      <= 1'b1;
`endif
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Bench for cacheline_adaptor: a transaction-level model is checked against the
// DUT on every falling edge, and directed scenarios pin data, address and latency
// with literal values. Honours CACHELINE_ADAPTOR_EARLY_RESP_EN like the RTL.
`timescale 1ns/1ps
module tb_cacheline_adaptor;
`ifdef CACHELINE_ADAPTOR_EARLY_RESP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         line_read = 1'b0, line_write = 1'b0;
  logic [31:0]  line_address = '0;
  logic [255:0] line_wdata = '0;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_address;
  logic         burst_read, burst_write;
  logic [63:0]  burst_wdata;
  logic [63:0]  burst_rdata = '0;
  logic         burst_resp = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_read(line_read), .line_write(line_write),
    .line_address(line_address), .line_wdata(line_wdata),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_address(burst_address), .burst_read(burst_read),
    .burst_write(burst_write), .burst_wdata(burst_wdata),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // kind: 0 none, 1 line read in flight, 2 line write in flight.
  int           m_kind = 0;
  int           m_beats = 0;
  bit           m_resp = 1'b0;
  logic [255:0] m_line = '0;
  logic [31:0]  m_addr = '0;

  always @(negedge clk) begin
    logic [255:0] e_rdata;
    logic [63:0]  e_wdata;
    bit           e_rd, e_wr, e_resp;
    if (!rst) begin
      m_kind = 0; m_beats = 0; m_resp = 1'b0; m_line = '0; m_addr = '0;
    end
    e_rd    = (m_kind == 1) && !m_resp;
    e_wr    = (m_kind == 2) && !m_resp;
    e_wdata = e_wr ? m_line[m_beats*64 +: 64] : 64'h0;
    e_resp  = EARLY ? ((m_kind != 0) && burst_resp && (m_beats == 3)) : m_resp;
    e_rdata = m_line;
    if (EARLY && (m_kind == 1) && burst_resp && (m_beats == 3)) e_rdata[255:192] = burst_rdata;
    check("m_read",  burst_read,    e_rd);
    check("m_write", burst_write,   e_wr);
    check("m_wdata", burst_wdata,   e_wdata);
    check("m_addr",  burst_address, m_addr);
    check("m_resp",  line_resp,     e_resp);
    check("m_rdata", line_rdata,    e_rdata);
    if (rst) begin
      if (m_resp) begin
        m_resp = 1'b0; m_kind = 0;
      end else if (m_kind == 0) begin
        if (line_read) begin
          m_kind = 1; m_beats = 0; m_addr = {line_address[31:5], 5'b0};
        end else if (line_write) begin
          m_kind = 2; m_beats = 0; m_addr = {line_address[31:5], 5'b0}; m_line = line_wdata;
        end
      end else if (burst_resp) begin
        if (m_kind == 1) m_line[m_beats*64 +: 64] = burst_rdata;
        m_beats++;
        if (m_beats == 4) begin
          m_beats = 0;
          if (EARLY) m_kind = 0; else m_resp = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
    burst_resp = 1'b0;
  endtask

  // Plays the memory side of one burst that is already active; returns the cycle
  // of the final beat and the cycle line_resp was seen (-1 if never).
  task automatic run_burst(input bit wr, input logic [255:0] ln, input int gap,
                           output int last_c, output int resp_c);
    last_c = 0;
    resp_c = -1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) step();
      if (wr) begin
        check("w_beat", burst_wdata, ln[i*64 +: 64]);
        check("w_no_rd", burst_read, 0);
      end else begin
        burst_rdata = ln[i*64 +: 64];
      end
      burst_resp = 1'b1;
      last_c = cyc;
      #2;
      if (i < 3) step();
    end
    for (int w = 0; w < 6 && resp_c < 0; w++) begin
      if (line_resp) resp_c = cyc;
      else step();
    end
    check("resp_seen", resp_c >= 0, 1);
  endtask

  localparam logic [255:0] RD1 = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
  localparam logic [255:0] W1  = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
  localparam logic [255:0] RD2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                  64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0};
  localparam logic [255:0] W2  = {64'h8888_7777_6666_5555, 64'h4444_3333_2222_1111,
                                  64'hCAFE_F00D_CAFE_F00D, 64'hDEAD_BEEF_DEAD_BEEF};
  localparam logic [255:0] STALE = {4{64'hEEEE_EEEE_EEEE_EEEE}};
  localparam logic [255:0] RD3 = {64'h3333_0000_0000_0003, 64'h2222_0000_0000_0002,
                                  64'h1111_0000_0000_0001, 64'h0000_0000_0000_0009};

  initial begin
    int req_c, last_c, resp_c;
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp",  line_resp, 0);
    check("rst_rdata", line_rdata, 0);
    check("rst_read",  burst_read, 0);
    check("rst_write", burst_write, 0);
    check("rst_addr",  burst_address, 0);
    check("rst_wdata", burst_wdata, 0);
    rst = 1'b1;
    step();

    // Stray acknowledge while idle must do nothing.
    burst_resp = 1'b1; burst_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    step(); step();
    check("idle_ack_rd", burst_read, 0);

    // Back-to-back read.
    line_address = 32'h0000_1234; line_read = 1'b1; req_c = cyc;
    step();
    check("rd1_cmd",  burst_read, 1);
    check("rd1_addr", burst_address, 32'h0000_1220);
    run_burst(1'b0, RD1, 0, last_c, resp_c);
    line_read = 1'b0;
    check("rd1_data", line_rdata, RD1);
    // Request-to-response span is 6 cycles (5 early) counting both end cycles.
    check("rd1_lat",  resp_c - req_c, EARLY ? 4 : 5);
    step();
    check("rd1_pulse", line_resp, 0);

    // Read with 3 idle cycles between beats.
    line_address = 32'h0000_1234; line_read = 1'b1; req_c = cyc;
    step();
    run_burst(1'b0, RD1, 3, last_c, resp_c);
    line_read = 1'b0;
    check("rd2_data", line_rdata, RD1);
    check("rd2_after_last", resp_c - last_c, EARLY ? 0 : 1);
    check("rd2_lat", resp_c - req_c, EARLY ? 13 : 14);
    step();

    // Write with 2-cycle gaps; each beat must hold until acknowledged.
    line_address = 32'h2000_005F; line_wdata = W1; line_write = 1'b1;
    step();
    check("wr_cmd",  burst_write, 1);
    check("wr_addr", burst_address, 32'h2000_0040);
    check("wr_beat0", burst_wdata, 64'hAAAA_AAAA_AAAA_AAAA);
    run_burst(1'b1, W1, 2, last_c, resp_c);
    line_write = 1'b0;
    check("wr_after_last", resp_c - last_c, EARLY ? 0 : 1);
    check("wr_rdata", line_rdata, W1);
    step();

    // Simultaneous read and write: read first, one idle cycle, then write.
    line_address = 32'h0000_0300; line_wdata = W2;
    line_read = 1'b1; line_write = 1'b1;
    step();
    check("sim_rd_first", burst_read, 1);
    check("sim_no_wr",    burst_write, 0);
    run_burst(1'b0, RD2, 0, last_c, resp_c);
    line_read = 1'b0;
    check("sim_rdata", line_rdata, RD2);
    step();
    check("sim_gap_rd", burst_read, 0);
    check("sim_gap_wr", burst_write, 0);
    step();
    check("sim_wr_start", burst_write, 1);
    run_burst(1'b1, W2, 0, last_c, resp_c);
    line_write = 1'b0;
    step();

    // Reset mid-read after two beats, then a fresh read of the same line.
    line_address = 32'h0000_0100; line_read = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      burst_resp = 1'b1; burst_rdata = STALE[i*64 +: 64];
      step();
    end
    rst = 1'b0; line_read = 1'b0;
    #1;
    check("mid_rst_read",  burst_read, 0);
    check("mid_rst_rdata", line_rdata, 0);
    check("mid_rst_addr",  burst_address, 0);
    check("mid_rst_resp",  line_resp, 0);
    step();
    rst = 1'b1;
    step();
    line_address = 32'h0000_0100; line_read = 1'b1;
    step();
    check("rd3_addr", burst_address, 32'h0000_0100);
    run_burst(1'b0, RD3, 1, last_c, resp_c);
    line_read = 1'b0;
    check("rd3_data", line_rdata, RD3);
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=completion");
    $fatal(1, "watchdog");
  end
endmodule
